// File: rtl/sll_32_seq.sv
// rtl/sll_32_seq.sv - multi-cycle 32-bit logical left shifter with start/busy/done handshake
module sll_32_seq #(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        shamt_src,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] res,
   output logic        zero
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // STEP is at most 16, so it always fits the 5-bit count width.
   localparam logic [4:0] STEP5 = 5'(STEP);

   state_t      state, state_n;
   logic [31:0] acc, acc_n;
   logic [4:0]  cnt, cnt_n;
   logic [4:0]  k;
   logic        busy_n, done_n, zero_n;
   logic [31:0] res_n;

   // Only B[10:6] and B[4:0] carry a shift amount; the rest of B is ignored.
   logic unused_b;
   assign unused_b = ^{B[31:11], B[5]};

   // Next-state and datapath: load on start, shift min(cnt, STEP) per cycle, publish when cnt hits 0.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      busy_n  = busy;
      done_n  = done;
      res_n   = res;
      zero_n  = zero;
      k       = (cnt < STEP5) ? cnt : STEP5;
      case (state)
         IDLE: begin
            // IDLE never completes, so done always drops here (one-cycle pulse).
            done_n = 1'b0;
            if (start) begin
               acc_n   = A;
               cnt_n   = shamt_src ? B[4:0] : B[10:6];
               busy_n  = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != 5'd0) begin
               // Final partial step shifts only the remaining count.
               acc_n = acc << k;
               cnt_n = cnt - k;
            end else begin
               res_n   = acc;
               zero_n  = (acc == 32'd0);
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any operation without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= 32'd0;
         cnt   <= 5'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         res   <= 32'd0;
         zero  <= 1'b1;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         res   <= res_n;
         zero  <= zero_n;
      end
   end

endmodule

// File: tb/tb_sll_32_seq.sv
// tb/tb_sll_32_seq.sv - directed self-checking bench for sll_32_seq (STEP=1 and STEP=4)
module tb_sll_32_seq;

   logic        clk;
   logic        rst;
   logic        start1, src1, start4, src4;
   logic [31:0] a1, b1, a4, b4;
   logic        busy1, done1, zero1, busy4, done4, zero4;
   logic [31:0] res1, res4;

   int total = 0;
   int bad   = 0;

   sll_32_seq u1 (
      .clk(clk), .rst(rst), .start(start1), .shamt_src(src1), .A(a1), .B(b1),
      .busy(busy1), .done(done1), .res(res1), .zero(zero1)
   );

   sll_32_seq #(.STEP(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .shamt_src(src4), .A(a4), .B(b4),
      .busy(busy4), .done(done4), .res(res4), .zero(zero4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic o_done(input bit w);
      return w ? done4 : done1;
   endfunction

   function automatic logic o_busy(input bit w);
      return w ? busy4 : busy1;
   endfunction

   function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [31:0] b, input bit src);
      logic [4:0] n;
      n = src ? b[4:0] : b[10:6];
      return a << n;
   endfunction

   task automatic drive(input bit w, input logic s, input logic [31:0] a, input logic [31:0] b, input bit src);
      if (w) begin
         start4 = s; a4 = a; b4 = b; src4 = src;
      end else begin
         start1 = s; a1 = a; b1 = b; src1 = src;
      end
   endtask

   // Single start pulse; counts edges from the sampling edge until done is seen.
   task automatic run_op(input bit w, input logic [31:0] a, input logic [31:0] b, input bit src,
                         input logic [31:0] exp_res, input int exp_edge, input string tag);
      int edge_n;
      int busy_n;
      int overlap;
      @(negedge clk);
      drive(w, 1'b1, a, b, src);
      @(posedge clk);
      edge_n = 1;
      @(negedge clk);
      drive(w, 1'b0, a, b, src);
      busy_n  = 0;
      overlap = 0;
      while (!o_done(w) && edge_n < 200) begin
         if (o_busy(w)) busy_n++;
         @(posedge clk);
         edge_n++;
         @(negedge clk);
      end
      if (o_busy(w) && o_done(w)) overlap = 1;
      chk({tag, ".done_edge"}, edge_n, exp_edge);
      chk({tag, ".res"}, w ? res4 : res1, exp_res);
      chk({tag, ".zero"}, w ? zero4 : zero1, {31'd0, exp_res == 32'd0});
      chk({tag, ".busy_cycles"}, busy_n, exp_edge - 1);
      chk({tag, ".busy_done_overlap"}, overlap, 0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".done_pulse_len"}, {31'd0, o_done(w)}, 32'd0);
   endtask

   logic [31:0] ops_a [4];
   logic [31:0] ops_b [4];
   bit          ops_s [4];

   initial begin
      int cyc;
      int dones;
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.busy1", {31'd0, busy1}, 32'd0);
      chk("rst.done1", {31'd0, done1}, 32'd0);
      chk("rst.res1", res1, 32'd0);
      chk("rst.zero1", {31'd0, zero1}, 32'd1);
      chk("rst.busy4", {31'd0, busy4}, 32'd0);
      chk("rst.res4", res4, 32'd0);
      chk("rst.zero4", {31'd0, zero4}, 32'd1);
      rst = 1'b0;

      run_op(1'b0, 32'h00000001, 32'h00000100, 1'b0, 32'h00000010, 6,  "s1_sh4");
      run_op(1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 2,  "s1_sh0");
      run_op(1'b0, 32'h00000003, 32'h000007C0, 1'b0, 32'h80000000, 33, "s1_sh31");
      run_op(1'b0, 32'h12345678, 32'h000007C8, 1'b1, 32'h34567800, 10, "s1_src1");
      run_op(1'b0, 32'h12345678, 32'h000007C8, 1'b0, 32'h00000000, 33, "s1_src0");
      run_op(1'b1, 32'h00000003, 32'h000007C0, 1'b0, 32'h80000000, 10, "s4_sh31");
      run_op(1'b1, 32'h00000003, 32'h00000140, 1'b0, 32'h00000060, 4,  "s4_sh5");
      run_op(1'b1, 32'h0000ABCD, 32'h00000010, 1'b1, 32'hABCD0000, 6,  "s4_sh16");

      // Start pulsed again with new operands while busy: must be ignored.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h00000001, 32'h00000100, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h00000001, 32'h00000100, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done1) begin
            dones++;
            chk("busy_start.res", res1, 32'h00000010);
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("busy_start.done_count", dones, 1);

      // Reset in the middle of a shift.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h00000003, 32'h000007C0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h00000003, 32'h000007C0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.busy", {31'd0, busy1}, 32'd0);
      chk("midrst.done", {31'd0, done1}, 32'd0);
      chk("midrst.res", res1, 32'd0);
      chk("midrst.zero", {31'd0, zero1}, 32'd1);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done1) dones++;
      end
      chk("midrst.no_done", dones, 0);

      // Start held high: back-to-back operations.
      ops_a[0] = 32'h0000000F; ops_b[0] = 32'h00000003; ops_s[0] = 1'b1;
      ops_a[1] = 32'h80000001; ops_b[1] = 32'h00000040; ops_s[1] = 1'b0;
      ops_a[2] = 32'hCAFEF00D; ops_b[2] = 32'h00000000; ops_s[2] = 1'b0;
      ops_a[3] = 32'h00FF00FF; ops_b[3] = 32'h0000001C; ops_s[3] = 1'b1;
      @(negedge clk);
      drive(1'b0, 1'b1, ops_a[0], ops_b[0], ops_s[0]);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b0, 1'b1, ops_a[i+1], ops_b[i+1], ops_s[i+1]);
         cyc = 0;
         while (!done1 && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("b2b%0d.done", i), {31'd0, done1}, 32'd1);
         chk($sformatf("b2b%0d.res", i), res1, ref_sll(ops_a[i], ops_b[i], ops_s[i]));
         if (i == 3) start1 = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b2b%0d.done_drop", i), {31'd0, done1}, 32'd0);
         chk($sformatf("b2b%0d.busy_next", i), {31'd0, busy1}, (i < 3) ? 32'd1 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
